// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART FSM states and baud divisor helper
package uart_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_e;

    // Clocks per bit, rounded to nearest.
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with sync clear, bit_end pulse every DIV clocks
module uart_baud_gen #(
    parameter int DIV = 1356
) (
    input  logic clk_i,
    input  logic rst_b_i,
    input  logic clr_i,
    input  logic en_i,
    output logic bit_end_o
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    // Held at zero while disabled so every bit period starts from a full count.
    always_ff @(posedge clk_i) begin
        if (!rst_b_i) begin
            cnt_q <= '0;
        end else if (clr_i || !en_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign bit_end_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/mcu_uart_tx.sv
// rtl/mcu_uart_tx.sv - FPGA->MCU UART transmitter, 8N1 by default, LSB first
// Define MCU_UART_TX_PARITY_EN to insert a parity bit between data and stop.
module mcu_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 156_250_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 parity_odd,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int DIV = uart_div(CLK_HZ, BAUD);
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("mcu_uart_tx: DIV=%0d must be at least 2", DIV);
        end
        if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_fmt
            $error("mcu_uart_tx: unsupported frame format");
        end
    endgenerate

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           bit_cnt_q;
    logic                 tx_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 accept;
    logic                 bit_end;

`ifdef MCU_UART_TX_PARITY_EN
    logic par_q;
    logic par_d;
    assign par_d = (^tx_data) ^ parity_odd;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    assign accept = tx_valid && ready_q;

    uart_baud_gen #(
        .DIV(DIV)
    ) u_baud (
        .clk_i    (clk),
        .rst_b_i  (rst_b),
        .clr_i    (accept),
        .en_i     (busy_q),
        .bit_end_o(bit_end)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MCU_UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        shift_q   <= tx_data;
                        bit_cnt_q <= '0;
                        tx_q      <= 1'b0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_START;
`ifdef MCU_UART_TX_PARITY_EN
                        par_q     <= par_d;
`endif
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_q <= '0;
`ifdef MCU_UART_TX_PARITY_EN
                            tx_q      <= par_q;
                            state_q   <= S_PARITY;
`else
                            tx_q      <= 1'b1;
                            state_q   <= S_STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (bit_cnt_q == LAST_STOP) begin
                            bit_cnt_q <= '0;
                            ready_q   <= 1'b1;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_mcu_uart_tx.sv
// tb/tb_mcu_uart_tx.sv - self-checking bench for mcu_uart_tx (DIV=10), honours MCU_UART_TX_PARITY_EN
module tb_mcu_uart_tx;

    localparam int DIV = 10;
`ifdef MCU_UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int N1 = 1 + 8 + P + 1;
    localparam int N2 = 1 + 8 + P + 2;

    logic       clk = 1'b0;
    logic       rst_b;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       parity_odd;
    logic       tx_ready, tx, busy, tx_done;
    logic [7:0] d2_data;
    logic       d2_valid;
    logic       d2_ready, d2_tx, d2_busy, d2_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_done = -1000;
    int start_gap = 0;
    logic mon_en = 1'b1;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mcu_uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .STOP_BITS(1)) dut (
        .clk(clk), .rst_b(rst_b), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .parity_odd(parity_odd), .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    mcu_uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_b(rst_b), .tx_data(d2_data), .tx_valid(d2_valid), .tx_ready(d2_ready),
        .parity_odd(1'b0), .tx(d2_tx), .busy(d2_busy), .tx_done(d2_done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Frame bit i is what the line should carry during the i-th bit period.
    function automatic logic [15:0] mk_frame(input logic [7:0] d, input logic ep);
        logic [15:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (P == 1) f[9] = ep;
        return f;
    endfunction

    typedef struct {
        logic [7:0] d;
        logic       po;
        logic       ep;
    } vec_t;

    // Line monitor for dut: checks every clock of every bit and the end-of-frame pulse.
    always begin : mon
        logic [15:0] got, exp;
        logic v;
        int hold_e, rdy_e, done_e;
        @(negedge clk);
        if (mon_en && rst_b && tx === 1'b0) begin
            start_gap = cyc - last_done;
            got = '1; hold_e = 0; rdy_e = 0; done_e = 0;
            for (int b = 0; b < N1; b++) begin
                v = tx;
                for (int c = 0; c < DIV; c++) begin
                    if (c > 0) @(negedge clk);
                    if (tx !== v) hold_e++;
                    if (tx_ready !== 1'b0 || busy !== 1'b1) rdy_e++;
                    if (tx_done !== 1'b0) done_e++;
                end
                got[b] = v;
                if (b < N1 - 1) @(negedge clk);
            end
            @(negedge clk);
            last_done = cyc;
            chk("end_of_frame {done,ready,busy,tx}", {28'd0, tx_done, tx_ready, busy, tx}, 32'hD);
            chk("bit_hold_glitches", hold_e, 0);
            chk("ready_busy_during_frame", rdy_e, 0);
            chk("early_tx_done", done_e, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", 1, 0);
            end else begin
                exp = exp_q.pop_front();
                chk("frame_bits", {16'd0, got}, {16'd0, exp});
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic po, input logic ep,
                        input logic keep, input logic push);
        int n;
        n = 0;
        tx_data = d; parity_odd = po; tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            chk("send_timeout", 1, 0);
            tx_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (push) exp_q.push_back(mk_frame(d, ep));
            @(negedge clk);
            if (!keep) tx_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_ready !== 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("idle_timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vec_t vecs[6];
        logic [15:0] got2;
        int ones, bad;

        vecs[0] = '{d: 8'h55, po: 1'b0, ep: 1'b0};
        vecs[1] = '{d: 8'h07, po: 1'b0, ep: 1'b1};
        vecs[2] = '{d: 8'h07, po: 1'b1, ep: 1'b0};
        vecs[3] = '{d: 8'hA3, po: 1'b0, ep: 1'b0};
        vecs[4] = '{d: 8'h80, po: 1'b1, ep: 1'b0};
        vecs[5] = '{d: 8'h01, po: 1'b0, ep: 1'b1};

        rst_b = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; parity_odd = 1'b0;
        d2_valid = 1'b0; d2_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_tx_ready", tx_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_tx_done", tx_done, 0);
        chk("reset_dut2_tx", d2_tx, 1);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].d, vecs[i].po, vecs[i].ep, 1'b0, 1'b1);
            wait_idle();
        end

        // Back-to-back with tx_valid held: one idle-high clock between frames.
        send(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle();
        chk("b2b_idle_gap", start_gap, 1);

        // Input changes while busy are ignored.
        send(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        tx_data = 8'hAA; tx_valid = 1'b1;
        repeat (30) @(negedge clk);
        tx_valid = 1'b0;
        wait_idle();

        // Reset at clock 45 of a frame aborts it silently.
        mon_en = 1'b0;
        send(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (44) @(negedge clk);
        chk("midframe_tx_low", tx, 0);
        rst_b = 1'b0;
        @(negedge clk);
        chk("abort {done,ready,busy,tx}", {28'd0, tx_done, tx_ready, busy, tx}, 32'h5);
        rst_b = 1'b1;
        bad = 0;
        repeat (150) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("no_resume_after_abort", bad, 0);
        mon_en = 1'b1;

        // Two stop bits on dut2.
        d2_data = 8'h80; d2_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d2_valid = 1'b0;
        got2 = '1; ones = 0; bad = 0;
        for (int k = 0; k < N2 * DIV; k++) begin
            if (k > 0) @(negedge clk);
            if (k % DIV == DIV / 2) got2[k / DIV] = d2_tx;
            if (k >= (N2 - 2) * DIV && d2_tx === 1'b1) ones++;
            if (d2_done !== 1'b0 || d2_ready !== 1'b0) bad++;
        end
        @(negedge clk);
        chk("dut2_frame_bits", {16'd0, got2}, {16'd0, mk_frame(8'h80, 1'b1)});
        chk("dut2_stop_high_clocks", ones, 2 * DIV);
        chk("dut2_ready_done_in_frame", bad, 0);
        chk("dut2_tx_done_at_end", d2_done, 1);
        @(negedge clk);
        chk("dut2_tx_done_one_clock", d2_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
